axil_cpu_if_bridge: RTL and testbench

AXI4-Lite slave that acts as the initiator on the cpu_if register bus. It drives broadsync CSR blocks and any other cpu_if responder. Each AXI read or write becomes one single-cycle cpu_if_read or cpu_if_write strobe. The bridge then waits for cpu_if_access_complete and returns the AXI response. A timeout converts a silent responder into SLVERR.

---
 rtl/cpu_if_pkg.sv | 19 +
 rtl/axil_cpu_if_bridge.sv | 249 ++++++++++++++++++++++++
 tb/tb_axil_cpu_if_bridge.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_if_pkg.sv
// Shared definitions for the cpu_if register-bus initiator: AXI response
// codes, bridge state encoding and the word-address offset.
package cpu_if_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // cpu_if addresses 32-bit words; byte-offset bits below this are dropped.
  localparam int CPU_IF_ADDR_LSB = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WWAIT = 3'd1,
    WRESP = 3'd2,
    RWAIT = 3'd3,
    RRESP = 3'd4
  } state_e;

endpackage

// File: rtl/axil_cpu_if_bridge.sv
// AXI4-Lite slave that turns each read or write into a single-cycle cpu_if
// strobe, waits for cpu_if_access_complete (or a timeout) and returns the
// AXI response. One cpu_if access is outstanding at a time; reads and writes
// alternate priority when both are waiting.
module axil_cpu_if_bridge
  import cpu_if_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  // AXI4-Lite write address
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  // AXI4-Lite write data
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  // AXI4-Lite write response
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  // AXI4-Lite read address
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  // AXI4-Lite read data
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  // cpu_if initiator
  output logic                  cpu_if_read,
  output logic                  cpu_if_write,
  output logic [31:0]           cpu_if_write_data,
  output logic [29:0]           cpu_if_address,
  input  logic [31:0]           cpu_if_read_data,
  input  logic                  cpu_if_access_complete
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic              prefer_read_q, prefer_read_d;
  logic [29:0]       awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpu_read_q, cpu_read_d;
  logic              cpu_write_q, cpu_write_d;
  logic [29:0]       cpu_addr_q, cpu_addr_d;
  logic [31:0]       cpu_wdata_q, cpu_wdata_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              idle;
  logic              strobe_cycle;
  logic              done_ok;
  logic              timed_out;
  logic [29:0]       aw_word;
  logic [29:0]       ar_word;
  logic              unused_addr_bits;

  // Word addresses, zero-extended to the 30-bit cpu_if address.
  assign aw_word = 30'(s_axil_awaddr[ADDR_WIDTH-1:CPU_IF_ADDR_LSB]);
  assign ar_word = 30'(s_axil_araddr[ADDR_WIDTH-1:CPU_IF_ADDR_LSB]);
  assign unused_addr_bits = ^{s_axil_awaddr[CPU_IF_ADDR_LSB-1:0],
                              s_axil_araddr[CPU_IF_ADDR_LSB-1:0]};

  // Ready signals are gated by reset so every output reads 0 while it is held.
  assign idle           = (state_q == IDLE) && !reset;
  assign s_axil_awready = idle && !aw_held_q;
  assign s_axil_wready  = idle && !w_held_q;
  assign s_axil_arready = idle && !aw_held_q && !w_held_q &&
                          (prefer_read_q || !s_axil_awvalid);

  // The strobe cycle itself is not part of the wait window: the counter and
  // the completion check start the cycle after the strobe.
  assign strobe_cycle = cpu_read_q | cpu_write_q;
  assign done_ok      = !strobe_cycle && cpu_if_access_complete;
  assign timed_out    = !strobe_cycle && (cnt_q == CNT_LAST);

  assign cpu_if_read       = cpu_read_q;
  assign cpu_if_write      = cpu_write_q;
  assign cpu_if_address    = cpu_addr_q;
  assign cpu_if_write_data = cpu_wdata_q;
  assign s_axil_bvalid     = bvalid_q;
  assign s_axil_bresp      = bresp_q;
  assign s_axil_rvalid     = rvalid_q;
  assign s_axil_rresp      = rresp_q;
  assign s_axil_rdata      = rdata_q;

  // Next-state logic: channel capture, access sequencing, timeout, responses.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned; that is what keeps this block from inferring latches.
    state_d       = state_q;
    aw_held_d     = aw_held_q;
    w_held_d      = w_held_q;
    prefer_read_d = prefer_read_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    cnt_d         = cnt_q;
    cpu_read_d    = 1'b0;
    cpu_write_d   = 1'b0;
    cpu_addr_d    = cpu_addr_q;
    cpu_wdata_d   = cpu_wdata_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    rvalid_d      = rvalid_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;

    if (s_axil_awvalid && s_axil_awready) begin
      aw_held_d = 1'b1;
      awaddr_d  = aw_word;
    end
    if (s_axil_wvalid && s_axil_wready) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end

    unique case (state_q)
      IDLE: begin
        if (aw_held_q && w_held_q) begin
          if (wstrb_q != 4'hF) begin
            // Partial writes are not supported by cpu_if: reject without a strobe.
            state_d  = WRESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
          end else begin
            state_d     = WWAIT;
            cpu_write_d = 1'b1;
            cpu_addr_d  = awaddr_q;
            cpu_wdata_d = wdata_q;
          end
        end else if (s_axil_arvalid && s_axil_arready) begin
          state_d    = RWAIT;
          cpu_read_d = 1'b1;
          cpu_addr_d = ar_word;
        end
      end

      WWAIT: begin
        cnt_d = strobe_cycle ? '0 : cnt_q + 1'b1;
        if (done_ok) begin
          state_d  = WRESP;
          bvalid_d = 1'b1;
          bresp_d  = RESP_OKAY;
        end else if (timed_out) begin
          state_d  = WRESP;
          bvalid_d = 1'b1;
          bresp_d  = RESP_SLVERR;
        end
      end

      RWAIT: begin
        cnt_d = strobe_cycle ? '0 : cnt_q + 1'b1;
        if (done_ok) begin
          state_d  = RRESP;
          rvalid_d = 1'b1;
          rresp_d  = RESP_OKAY;
          rdata_d  = cpu_if_read_data;
        end else if (timed_out) begin
          state_d  = RRESP;
          rvalid_d = 1'b1;
          rresp_d  = RESP_SLVERR;
          rdata_d  = '0;
        end
      end

      WRESP: begin
        if (s_axil_bready) begin
          state_d       = IDLE;
          bvalid_d      = 1'b0;
          aw_held_d     = 1'b0;
          w_held_d      = 1'b0;
          prefer_read_d = 1'b1;
        end
      end

      RRESP: begin
        // A W beat accepted alongside AR stays held for the following write.
        if (s_axil_rready) begin
          state_d       = IDLE;
          rvalid_d      = 1'b0;
          prefer_read_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous, active-high reset of every flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      prefer_read_q <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      cnt_q         <= '0;
      cpu_read_q    <= 1'b0;
      cpu_write_q   <= 1'b0;
      cpu_addr_q    <= '0;
      cpu_wdata_q   <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= '0;
      rvalid_q      <= 1'b0;
      rresp_q       <= '0;
      rdata_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed before this edge, independent of statement order.
      state_q       <= state_d;
      aw_held_q     <= aw_held_d;
      w_held_q      <= w_held_d;
      prefer_read_q <= prefer_read_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      cnt_q         <= cnt_d;
      cpu_read_q    <= cpu_read_d;
      cpu_write_q   <= cpu_write_d;
      cpu_addr_q    <= cpu_addr_d;
      cpu_wdata_q   <= cpu_wdata_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axil_cpu_if_bridge.sv
// Self-checking bench for axil_cpu_if_bridge: directed cases plus randomized
// transactions checked against a transaction-level model of the bridge.
module tb_axil_cpu_if_bridge;
  import cpu_if_pkg::*;

  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] s_axil_awaddr;
  logic          s_axil_awvalid;
  logic          s_axil_awready;
  logic [31:0]   s_axil_wdata;
  logic [3:0]    s_axil_wstrb;
  logic          s_axil_wvalid;
  logic          s_axil_wready;
  logic [1:0]    s_axil_bresp;
  logic          s_axil_bvalid;
  logic          s_axil_bready;
  logic [AW-1:0] s_axil_araddr;
  logic          s_axil_arvalid;
  logic          s_axil_arready;
  logic [31:0]   s_axil_rdata;
  logic [1:0]    s_axil_rresp;
  logic          s_axil_rvalid;
  logic          s_axil_rready;
  logic          cpu_if_read;
  logic          cpu_if_write;
  logic [31:0]   cpu_if_write_data;
  logic [29:0]   cpu_if_address;
  logic [31:0]   cpu_if_read_data;
  logic          cpu_if_access_complete;

  axil_cpu_if_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .cpu_if_read(cpu_if_read), .cpu_if_write(cpu_if_write), .cpu_if_write_data(cpu_if_write_data),
    .cpu_if_address(cpu_if_address), .cpu_if_read_data(cpu_if_read_data),
    .cpu_if_access_complete(cpu_if_access_complete)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Responder controls (written only by the main thread).
  int          resp_delay   = 1;   // cycles after strobe to complete; 0 = never
  int          inject_cycle = -1;  // stray completion pulse at this cycle
  logic [31:0] rd_val       = '0;

  // Strobe log (written only by the responder).
  bit          sk[$];              // 1 = write, 0 = read
  logic [29:0] sa[$];
  logic [31:0] sd[$];
  int          sc[$];
  int          both_err = 0;

  // Behavioural cpu_if responder; logs every strobe cycle it sees.
  initial begin
    int  pending = 0;
    bit  fire;
    cpu_if_access_complete = 1'b0;
    cpu_if_read_data       = '0;
    forever begin
      @(posedge clk); #1;
      fire = 1'b0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) fire = 1'b1;
      end
      if (cyc == inject_cycle) fire = 1'b1;
      if (cpu_if_read || cpu_if_write) begin
        if (cpu_if_read && cpu_if_write) both_err++;
        sk.push_back(cpu_if_write);
        sa.push_back(cpu_if_address);
        sd.push_back(cpu_if_write_data);
        sc.push_back(cyc);
        pending = resp_delay;
      end
      cpu_if_access_complete = fire;
      cpu_if_read_data       = fire ? rd_val : $urandom();
    end
  end

  // Reference model: a completion d cycles after the strobe wins if it is
  // within the TO-cycle wait window; otherwise the access times out.
  function automatic bit model_ok(input int d);
    return (d >= 1) && (d <= TO);
  endfunction
  function automatic int model_latency(input int d);
    return model_ok(d) ? d + 1 : TO + 1;
  endfunction
  function automatic logic [1:0] model_resp(input int d);
    return model_ok(d) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_p = 1'b1, w_p = 1'b1, a, w;
    int n = 0;
    int wdl = int'($urandom_range(0, 2));
    s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
    s_axil_awvalid = 1'b1;
    while ((aw_p || w_p) && n < 60) begin
      s_axil_wvalid = w_p && (n >= wdl);
      @(negedge clk);
      a = s_axil_awvalid && s_axil_awready;
      w = s_axil_wvalid && s_axil_wready;
      @(posedge clk); #1;
      if (a) begin aw_p = 1'b0; s_axil_awvalid = 1'b0; end
      if (w) begin w_p = 1'b0; s_axil_wvalid = 1'b0; end
      n++;
    end
    check("aw_w_accepted", {aw_p, w_p}, 2'b00);
  endtask

  task automatic send_ar(input logic [31:0] addr);
    bit ar_p = 1'b1, r;
    int n = 0;
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    while (ar_p && n < 60) begin
      @(negedge clk);
      r = s_axil_arvalid && s_axil_arready;
      @(posedge clk); #1;
      if (r) begin ar_p = 1'b0; s_axil_arvalid = 1'b0; end
      n++;
    end
    check("ar_accepted", ar_p, 1'b0);
  endtask

  task automatic wait_b(output logic [1:0] resp, output int bcyc);
    bit done = 1'b0;
    int n = 0;
    resp = 'x; bcyc = -1;
    s_axil_bready = 1'b1;
    while (!done && n < 100) begin
      @(negedge clk);
      if (s_axil_bvalid) begin done = 1'b1; resp = s_axil_bresp; bcyc = cyc; end
      @(posedge clk); #1;
      n++;
    end
    s_axil_bready = 1'b0;
    check("b_seen", done, 1'b1);
  endtask

  task automatic wait_r(output logic [1:0] resp, output logic [31:0] data, output int rcyc);
    bit done = 1'b0;
    int n = 0;
    resp = 'x; data = 'x; rcyc = -1;
    s_axil_rready = 1'b1;
    while (!done && n < 100) begin
      @(negedge clk);
      if (s_axil_rvalid) begin done = 1'b1; resp = s_axil_rresp; data = s_axil_rdata; rcyc = cyc; end
      @(posedge clk); #1;
      n++;
    end
    s_axil_rready = 1'b0;
    check("r_seen", done, 1'b1);
  endtask

  task automatic do_write_chk(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int d);
    int n0 = sk.size();
    logic [1:0] resp;
    int bcyc;
    resp_delay = d;
    send_aw_w(addr, data, strb);
    wait_b(resp, bcyc);
    if (strb != 4'hF) begin
      check("wr_partial_no_strobe", sk.size(), n0);
      check("wr_partial_bresp", resp, RESP_SLVERR);
    end else begin
      check("wr_strobe_count", sk.size(), n0 + 1);
      if (sk.size() > n0) begin
        check("wr_kind", sk[n0], 1'b1);
        check("wr_addr", sa[n0], addr[31:2]);
        check("wr_data", sd[n0], data);
        check("wr_latency", bcyc - sc[n0], model_latency(d));
      end
      check("wr_bresp", resp, model_resp(d));
    end
  endtask

  task automatic do_read_chk(input logic [31:0] addr, input int d);
    int n0 = sk.size();
    logic [1:0] resp;
    logic [31:0] data;
    int rcyc;
    resp_delay = d;
    rd_val = $urandom();
    send_ar(addr);
    wait_r(resp, data, rcyc);
    check("rd_strobe_count", sk.size(), n0 + 1);
    if (sk.size() > n0) begin
      check("rd_kind", sk[n0], 1'b0);
      check("rd_addr", sa[n0], addr[31:2]);
      check("rd_latency", rcyc - sc[n0], model_latency(d));
    end
    check("rd_rresp", resp, model_resp(d));
    check("rd_data", data, model_ok(d) ? rd_val : 32'h0);
  endtask

  // AW, W and AR presented together; both responses collected.
  task automatic triple(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                        output logic [1:0] br, output logic [1:0] rr, output logic [31:0] rd);
    bit aw_p = 1'b1, w_p = 1'b1, ar_p = 1'b1, gb = 1'b0, gr = 1'b0, a, w, r;
    int n = 0;
    br = 'x; rr = 'x; rd = 'x;
    s_axil_awaddr = wa; s_axil_wdata = wd; s_axil_wstrb = 4'hF; s_axil_araddr = ra;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    while ((aw_p || w_p || ar_p || !gb || !gr) && n < 200) begin
      @(negedge clk);
      a = s_axil_awvalid && s_axil_awready;
      w = s_axil_wvalid && s_axil_wready;
      r = s_axil_arvalid && s_axil_arready;
      if (s_axil_bvalid && !gb) begin gb = 1'b1; br = s_axil_bresp; end
      if (s_axil_rvalid && !gr) begin gr = 1'b1; rr = s_axil_rresp; rd = s_axil_rdata; end
      @(posedge clk); #1;
      if (a) begin aw_p = 1'b0; s_axil_awvalid = 1'b0; end
      if (w) begin w_p = 1'b0; s_axil_wvalid = 1'b0; end
      if (r) begin ar_p = 1'b0; s_axil_arvalid = 1'b0; end
      n++;
    end
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    check("triple_done", {aw_p, w_p, ar_p, gb, gr}, 5'b00011);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid,
                          s_axil_rvalid, s_axil_bresp, s_axil_rresp, cpu_if_read, cpu_if_write}, '0);
    check({tag, "_data"}, {s_axil_rdata, cpu_if_address}, '0);
    check({tag, "_wdata"}, cpu_if_write_data, '0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd, wa, wd;
    int          n0, d, bcyc;

    reset = 1'b1;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_wvalid = 1'b0; s_axil_bready = 1'b0; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b0;

    apply_reset();
    @(posedge clk); #1;
    check("idle_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

    // Basic write and read with minimum responder latency.
    do_write_chk(32'h0000_0004, 32'h0000_1234, 4'hF, 1);
    resp_delay = 1;
    begin
      n0 = sk.size();
      rd_val = 32'hA5A5_0001;
      send_ar(32'h0000_0028);
      wait_r(rr, rd, bcyc);
      check("rd_fixed_addr", sa[n0], 30'hA);
      check("rd_fixed_data", rd, 32'hA5A5_0001);
      check("rd_fixed_resp", rr, RESP_OKAY);
      check("rd_fixed_latency", bcyc - sc[n0], 2);
    end

    // Timeout, then a stray completion that must be ignored.
    do_write_chk(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0);
    inject_cycle = cyc + 3;
    repeat (6) begin
      @(negedge clk);
      check("stray_complete_ignored", {s_axil_bvalid, s_axil_rvalid, cpu_if_read, cpu_if_write}, 4'b0);
      @(posedge clk); #1;
    end
    do_read_chk(32'h0000_0104, 1);

    // Timeout boundary: completion on the last wait cycle wins, one later loses.
    do_read_chk(32'h0000_0200, TO);
    do_read_chk(32'h0000_0204, TO + 1);
    do_write_chk(32'h0000_0208, 32'h1111_2222, 4'hF, TO);

    // Partial strobe is rejected without a cpu_if access.
    do_write_chk(32'h0000_0300, 32'h3333_4444, 4'h3, 1);

    // Response held with bready low while a new write is offered.
    resp_delay = 2;
    n0 = sk.size();
    send_aw_w(32'h0000_0400, 32'h0000_0AAA, 4'hF);
    d = 0;
    while (!s_axil_bvalid && d < 40) begin @(posedge clk); #1; d++; end
    check("hold_b_arrived", s_axil_bvalid, 1'b1);
    s_axil_awaddr = 32'h0000_0404; s_axil_wdata = 32'h0000_0BBB; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_bvalid_bresp", {s_axil_bvalid, s_axil_bresp}, {1'b1, RESP_OKAY});
      check("hold_not_ready", {s_axil_awready, s_axil_wready}, 2'b00);
      check("hold_no_strobe", sk.size(), n0 + 1);
      @(posedge clk); #1;
    end
    wait_b(br, bcyc);
    check("hold_first_bresp", br, RESP_OKAY);
    send_aw_w(32'h0000_0404, 32'h0000_0BBB, 4'hF);
    wait_b(br, bcyc);
    check("hold_second_bresp", br, RESP_OKAY);
    check("hold_second_strobe", sk.size(), n0 + 2);
    check("hold_second_addr", sa[n0 + 1], 30'h101);
    check("hold_second_data", sd[n0 + 1], 32'h0000_0BBB);

    // Simultaneous AW/W/AR straight out of reset: write goes first.
    apply_reset();
    resp_delay = 2;
    rd_val = 32'h0BAD_F00D;
    n0 = sk.size();
    triple(32'h0000_0010, 32'h5555_6666, 32'h0000_0020, br, rr, rd);
    check("arb1_count", sk.size(), n0 + 2);
    check("arb1_order", {sk[n0], sk[n0 + 1]}, 2'b10);
    check("arb1_resps", {br, rr}, {RESP_OKAY, RESP_OKAY});
    check("arb1_rdata", rd, 32'h0BAD_F00D);
    // After a completed write, a simultaneous triple is served read first.
    do_write_chk(32'h0000_0030, 32'h7777_8888, 4'hF, 1);
    resp_delay = 3;
    n0 = sk.size();
    triple(32'h0000_0040, 32'h9999_AAAA, 32'h0000_0050, br, rr, rd);
    check("arb2_order", {sk[n0], sk[n0 + 1]}, 2'b01);
    check("arb2_addrs", {sa[n0], sa[n0 + 1]}, {30'h14, 30'h10});
    check("arb2_rdata", rd, 32'h0BAD_F00D);

    // Reset while a read is waiting; a late completion must not surface.
    resp_delay = 0;
    send_ar(32'h0000_0060);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset_in_rwait");
    reset = 1'b0;
    inject_cycle = cyc + 2;
    repeat (6) begin
      @(negedge clk);
      check("no_resp_after_reset", {s_axil_rvalid, s_axil_bvalid}, 2'b00);
      @(posedge clk); #1;
    end
    do_write_chk(32'h0000_0070, 32'hCAFE_0001, 4'hF, 3);

    // Randomized mix of reads and writes against the model.
    for (int i = 0; i < 60; i++) begin
      wa = $urandom();
      wd = $urandom();
      d  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 2));
      if ($urandom_range(0, 1) == 1) begin
        do_write_chk(wa, wd, ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF, d);
      end else begin
        do_read_chk(wa, d);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    check("never_both_strobes", both_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
